// File: rtl/buzzer_note_player.sv
// buzzer_note_player
// Plays a queue of timed square-wave notes on a buzzer pin. Each note is a
// half-period (pitch, in clocks; 0 = rest) plus a duration (in prescaled ticks;
// 0 = one-clock note). A one-entry pending slot lets a note queued during the
// current one start on the very edge the current one ends.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_valid        note request valid
//   o_ready        pending slot free (transfer on i_valid && o_ready)
//   i_half_period  tone half-period in clocks, 0 = rest
//   i_duration     note length in ticks, 0 = minimum-length note
//   i_stop         synchronous abort of current and pending notes
//   o_sound        square-wave buzzer drive
//   o_busy         note playing or pending
//   o_done         one-cycle pulse at each note completion
module buzzer_note_player #(
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned DUR_W    = 16,
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [DIV_W-1:0] i_half_period,
    input  logic [DUR_W-1:0] i_duration,
    input  logic             i_stop,
    output logic             o_sound,
    output logic             o_busy,
    output logic             o_done
);

    // Prescaler needs at least one bit even when TICK_DIV == 1.
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    typedef enum logic {
        StIdle,
        StPlay
    } state_t;

    state_t             state_q, state_d;
    logic               pend_valid_q, pend_valid_d;
    logic [DIV_W-1:0]   pend_half_q, pend_half_d;
    logic [DUR_W-1:0]   pend_dur_q, pend_dur_d;
    logic [DIV_W-1:0]   act_half_q, act_half_d;
    logic [DUR_W-1:0]   act_dur_q, act_dur_d;
    logic [DIV_W-1:0]   tone_cnt_q, tone_cnt_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
    logic               sound_q, sound_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic accept;
    logic note_last;
    logic load;

    assign o_ready = !pend_valid_q && !i_stop && !i_reset;
    assign accept  = i_valid && o_ready;

    // Last cycle of the active note: D == 0 lasts one clock, otherwise the
    // final prescaler count of the final tick.
    assign note_last = (act_dur_q == '0) ||
                       ((presc_q == PRE_MAX) && (dur_cnt_q == act_dur_q - DUR_W'(1)));

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_half_d  = pend_half_q;
        pend_dur_d   = pend_dur_q;
        act_half_d   = act_half_q;
        act_dur_d    = act_dur_q;
        tone_cnt_d   = tone_cnt_q;
        presc_d      = presc_q;
        dur_cnt_d    = dur_cnt_q;
        sound_d      = sound_q;
        done_d       = 1'b0;
        load         = 1'b0;

        if (i_stop) begin
            state_d      = StIdle;
            pend_valid_d = 1'b0;
            tone_cnt_d   = '0;
            presc_d      = '0;
            dur_cnt_d    = '0;
            sound_d      = 1'b0;
        end else begin
            if (accept) begin
                pend_valid_d = 1'b1;
                pend_half_d  = i_half_period;
                pend_dur_d   = i_duration;
            end

            unique case (state_q)
                StIdle: begin
                    if (pend_valid_q) begin
                        load = 1'b1;
                    end
                end
                StPlay: begin
                    if (note_last) begin
                        done_d     = 1'b1;
                        sound_d    = 1'b0;
                        tone_cnt_d = '0;
                        presc_d    = '0;
                        dur_cnt_d  = '0;
                        if (pend_valid_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        if (presc_q == PRE_MAX) begin
                            presc_d   = '0;
                            dur_cnt_d = dur_cnt_q + DUR_W'(1);
                        end else begin
                            presc_d = presc_q + PRE_W'(1);
                        end
                        // Rests keep the tone counter and output parked at 0.
                        if (act_half_q != '0) begin
                            if (tone_cnt_q == act_half_q - DIV_W'(1)) begin
                                tone_cnt_d = '0;
                                sound_d    = !sound_q;
                            end else begin
                                tone_cnt_d = tone_cnt_q + DIV_W'(1);
                            end
                        end
                    end
                end
            endcase

            if (load) begin
                state_d      = StPlay;
                act_half_d   = pend_half_q;
                act_dur_d    = pend_dur_q;
                pend_valid_d = 1'b0;
                tone_cnt_d   = '0;
                presc_d      = '0;
                dur_cnt_d    = '0;
                sound_d      = 1'b0;
            end
        end

        // Registered so o_busy never glitches between state and slot updates.
        busy_d = (state_d == StPlay) || pend_valid_d;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= StIdle;
            pend_valid_q <= 1'b0;
            pend_half_q  <= '0;
            pend_dur_q   <= '0;
            act_half_q   <= '0;
            act_dur_q    <= '0;
            tone_cnt_q   <= '0;
            presc_q      <= '0;
            dur_cnt_q    <= '0;
            sound_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_half_q  <= pend_half_d;
            pend_dur_q   <= pend_dur_d;
            act_half_q   <= act_half_d;
            act_dur_q    <= act_dur_d;
            tone_cnt_q   <= tone_cnt_d;
            presc_q      <= presc_d;
            dur_cnt_q    <= dur_cnt_d;
            sound_q      <= sound_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign o_sound = sound_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_buzzer_note_player.sv
// Bench for buzzer_note_player with TICK_DIV = 4. The stimulus process drives
// one clock cycle at a time and pushes the outputs it expects for that cycle
// into a queue; the monitor pops one entry per falling edge and compares.
module tb_buzzer_note_player;

    localparam int unsigned DIV_W    = 16;
    localparam int unsigned DUR_W    = 16;
    localparam int unsigned TICK_DIV = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid;
    logic             ready;
    logic [DIV_W-1:0] half;
    logic [DUR_W-1:0] dur;
    logic             stop;
    logic             sound;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;
    int done_seen = 0;

    // Expected {sound, busy, done, ready} per cycle, with a name per entry.
    logic [3:0] exp_q[$];
    string      name_q[$];

    buzzer_note_player #(
        .DIV_W   (DIV_W),
        .DUR_W   (DUR_W),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_valid      (valid),
        .o_ready      (ready),
        .i_half_period(half),
        .i_duration   (dur),
        .i_stop       (stop),
        .o_sound      (sound),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per falling edge while any are queued.
    always @(negedge clk) begin
        logic [3:0] e;
        string      n;
        if (done === 1'b1) done_seen++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if ({sound, busy, done, ready} !== e) begin
                failures++;
                $display("FAIL %s t=%0t: got sound=%b busy=%b done=%b ready=%b, expected sound=%b busy=%b done=%b ready=%b",
                         n, $time, sound, busy, done, ready, e[3], e[2], e[1], e[0]);
            end
        end
    end

    task automatic push(input logic s, input logic b, input logic d, input logic r,
                        input string n);
        exp_q.push_back({s, b, d, r});
        name_q.push_back(n);
    endtask

    // Drive one cycle's inputs just after the rising edge and queue its expectation.
    task automatic tick(input logic v, input logic [DIV_W-1:0] h, input logic [DUR_W-1:0] d,
                        input logic st, input logic es, input logic eb, input logic ed,
                        input logic er, input string n);
        @(posedge clk);
        #1;
        valid = v;
        half  = h;
        dur   = d;
        stop  = st;
        push(es, eb, ed, er, n);
    endtask

    logic pat2[8];
    logic pat3a[4];
    logic pat3b[4];
    logic pat5[8];

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        half  = '0;
        dur   = '0;
        stop  = 1'b0;
        pat2  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        pat3a = '{1'b0, 1'b0, 1'b1, 1'b1};
        pat3b = '{1'b0, 1'b1, 1'b0, 1'b1};
        pat5  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset held three cycles, then released.
        repeat (3) tick(0, 0, 0, 0, 0, 0, 0, 0, "reset_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(0, 0, 0, 1, "reset_release");

        // Single note H=3 D=2: 8 playing cycles.
        tick(1, 3, 2, 0, 0, 0, 0, 1, "t2_offer");
        tick(0, 0, 0, 0, 0, 1, 0, 0, "t2_pending");
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 0, pat2[i], 1, 0, 1, "t2_play");
        tick(0, 0, 0, 0, 0, 0, 1, 1, "t2_done");
        tick(0, 0, 0, 0, 0, 0, 0, 1, "t2_idle");

        // Back-to-back A (H=2 D=1) then B (H=1 D=1), B queued while A plays.
        tick(1, 2, 1, 0, 0, 0, 0, 1, "t3_offer_a");
        tick(0, 0, 0, 0, 0, 1, 0, 0, "t3_pending_a");
        tick(1, 1, 1, 0, pat3a[0], 1, 0, 1, "t3_a_offer_b");
        for (int i = 1; i < 4; i++) tick(0, 0, 0, 0, pat3a[i], 1, 0, 0, "t3_a_play");
        tick(0, 0, 0, 0, pat3b[0], 1, 1, 1, "t3_b_first_done_a");
        for (int i = 1; i < 4; i++) tick(0, 0, 0, 0, pat3b[i], 1, 0, 1, "t3_b_play");
        tick(0, 0, 0, 0, 0, 0, 1, 1, "t3_done_b");
        tick(0, 0, 0, 0, 0, 0, 0, 1, "t3_idle");

        // Rest H=0 D=3: silent for 12 cycles.
        tick(1, 0, 3, 0, 0, 0, 0, 1, "t4_offer");
        tick(0, 0, 0, 0, 0, 1, 0, 0, "t4_pending");
        for (int i = 0; i < 12; i++) tick(0, 0, 0, 0, 0, 1, 0, 1, "t4_rest");
        tick(0, 0, 0, 0, 0, 0, 1, 1, "t4_done");
        tick(0, 0, 0, 0, 0, 0, 0, 1, "t4_idle");

        // H=5 D=10 with a pending note, stopped during play cycle 7.
        tick(1, 5, 10, 0, 0, 0, 0, 1, "t5_offer");
        tick(0, 0, 0, 0, 0, 1, 0, 0, "t5_pending");
        tick(1, 2, 1, 0, pat5[0], 1, 0, 1, "t5_offer_next");
        for (int i = 1; i < 7; i++) tick(0, 0, 0, 0, pat5[i], 1, 0, 0, "t5_play");
        tick(0, 0, 0, 1, pat5[7], 1, 0, 0, "t5_stop");
        tick(0, 0, 0, 0, 0, 0, 0, 1, "t5_flushed");
        tick(0, 0, 0, 0, 0, 0, 0, 1, "t5_stay_idle");
        tick(0, 0, 0, 0, 0, 0, 0, 1, "t5_stay_idle");

        // D=0 note: exactly one playing cycle.
        tick(1, 2, 0, 0, 0, 0, 0, 1, "t6_offer");
        tick(0, 0, 0, 0, 0, 1, 0, 0, "t6_pending");
        tick(0, 0, 0, 0, 0, 1, 0, 1, "t6_play");
        tick(0, 0, 0, 0, 0, 0, 1, 1, "t6_done");
        tick(0, 0, 0, 0, 0, 0, 0, 1, "t6_idle");

        // Async reset mid-note of H=2 D=5, while o_sound is high.
        tick(1, 2, 5, 0, 0, 0, 0, 1, "t7_offer");
        tick(0, 0, 0, 0, 0, 1, 0, 0, "t7_pending");
        tick(0, 0, 0, 0, 0, 1, 0, 1, "t7_play");
        tick(0, 0, 0, 0, 0, 1, 0, 1, "t7_play");
        tick(0, 0, 0, 0, 1, 1, 0, 1, "t7_play");
        @(posedge clk);
        #1;
        push(0, 0, 0, 0, "t7_async_reset");
        #1;
        rst = 1'b1;
        tick(0, 0, 0, 0, 0, 0, 0, 0, "t7_reset_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(0, 0, 0, 1, "t7_release");
        repeat (6) tick(0, 0, 0, 0, 0, 0, 0, 1, "t7_no_done");

        // Let the monitor drain, bounded.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end
        checks++;
        if (done_seen != 5) begin
            failures++;
            $display("FAIL done_count: got %0d o_done pulses, expected 5", done_seen);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
